// File: rtl/cpa_accum_ctrl_if.sv
// rtl/cpa_accum_ctrl_if.sv - operand stream, adder hookup and result stream bundle for cpa_accum_ctrl
//
// Purpose: groups every non-clock/reset signal of the accumulation controller.
//   slave  modport: the controller's view.
//   master modport: the surrounding environment (operand source, adder, result sink).
// Signals:
//   in_valid/in_ready/in_data       operand stream (signed, WIDTH bits)
//   add_a/add_b                     controller -> adder operands
//   add_s/add_cout/add_ovf          adder -> controller sum and flags
//   out_valid/out_ready/out_sum     result stream
//   out_ovf/out_cout                sticky flags accompanying out_sum
interface cpa_accum_ctrl_if #(
  parameter int WIDTH = 13
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             add_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic             out_cout;

  modport slave (
    input  in_valid, in_data, add_s, add_cout, add_ovf, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, out_ovf, out_cout
  );

  modport master (
    output in_valid, in_data, add_s, add_cout, add_ovf, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, out_ovf, out_cout
  );
endinterface

// File: rtl/cpa_accum_ctrl.sv
// rtl/cpa_accum_ctrl.sv - sequential accumulation controller around an external ripple-carry adder
//
// Purpose: accepts COUNT signed operands, feeds acc/operand to an external
//   combinational adder, folds the adder result back into acc (saturating on
//   signed overflow when SAT=1) and offers the final sum with sticky
//   overflow/carry flags on a valid/ready result port.
// Parameters: WIDTH (must match the adder), COUNT (1..255), SAT (1 saturate, 0 wrap).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    cpa_accum_ctrl_if.slave (operand stream, adder a/b/s/flags, result stream)
module cpa_accum_ctrl #(
  parameter int WIDTH = 13,
  parameter int COUNT = 4,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  cpa_accum_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [7:0]       LAST_CNT = 8'(COUNT - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [7:0]       cnt, cnt_n;
  logic             ovf_sticky, ovf_n;
  logic             cout_sticky, cout_n;
  logic             in_ready_q, out_valid_q;
  logic             accept;

  // in_ready is a register so it never follows out_ready combinationally.
  assign accept = bus.in_valid && in_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOAD;
      acc         <= '0;
      cnt         <= '0;
      ovf_sticky  <= 1'b0;
      cout_sticky <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      ovf_sticky  <= ovf_n;
      cout_sticky <= cout_n;
      in_ready_q  <= (state_n != S_OUT);
      out_valid_q <= (state_n == S_OUT);
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf_sticky;
    cout_n  = cout_sticky;

    case (state)
      S_LOAD: begin
        // First operand seeds acc directly; adder output is meaningless here.
        if (accept) begin
          acc_n   = bus.in_data;
          cnt_n   = 8'd1;
          ovf_n   = 1'b0;
          cout_n  = 1'b0;
          state_n = (COUNT == 1) ? S_OUT : S_ACC;
        end
      end

      S_ACC: begin
        if (accept) begin
          cnt_n  = cnt + 8'd1;
          ovf_n  = ovf_sticky | bus.add_ovf;
          cout_n = cout_sticky | bus.add_cout;
          // Overflow only happens when both operands share a sign, so the
          // operand's sign bit tells which rail to clamp to.
          if (SAT && bus.add_ovf) begin
            acc_n = bus.in_data[WIDTH-1] ? SAT_MIN : SAT_MAX;
          end else begin
            acc_n = bus.add_s;
          end
          if (cnt == LAST_CNT) begin
            state_n = S_OUT;
          end
        end
      end

      S_OUT: begin
        // acc is held so the result stays stable and survives until the next load.
        if (out_valid_q && bus.out_ready) begin
          state_n = S_LOAD;
        end
      end

      default: begin
        state_n = S_LOAD;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.add_a     = acc;
  assign bus.add_b     = bus.in_data;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf_sticky;
  assign bus.out_cout  = cout_sticky;

endmodule

// File: tb/tb_cpa_accum_ctrl.sv
// tb/tb_cpa_accum_ctrl.sv - self-checking bench for cpa_accum_ctrl (three parameter sets)
module tb_cpa_accum_ctrl;

  // inst 0: COUNT=4 SAT=1, inst 1: COUNT=4 SAT=0, inst 2: COUNT=1 SAT=1
  logic clk;
  logic reset;

  logic [2:0]       vld;
  logic [2:0][12:0] dat;
  logic [2:0]       ordy;

  logic [2:0]       rdy_w;
  logic [2:0]       ov_w;
  logic [2:0]       oovf_w;
  logic [2:0]       ocout_w;
  logic [2:0][12:0] sum_w;
  logic [2:0][12:0] adda_w;
  logic [2:0][12:0] addb_w;

  int n_checks = 0;
  int n_errors = 0;

  cpa_accum_ctrl_if #(.WIDTH(13)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [13:0] wide;

    cpa_accum_ctrl #(
      .WIDTH(13),
      .COUNT((g == 2) ? 1 : 4),
      .SAT((g == 1) ? 1'b0 : 1'b1)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus[g])
    );

    // Reference ripple adder: plain 14-bit addition plus sign-rule overflow.
    assign wide            = {1'b0, bus[g].add_a} + {1'b0, bus[g].add_b};
    assign bus[g].add_s    = wide[12:0];
    assign bus[g].add_cout = wide[13];
    assign bus[g].add_ovf  = (bus[g].add_a[12] == bus[g].add_b[12]) && (wide[12] != bus[g].add_a[12]);

    assign bus[g].in_valid  = vld[g];
    assign bus[g].in_data   = dat[g];
    assign bus[g].out_ready = ordy[g];
    assign rdy_w[g]   = bus[g].in_ready;
    assign ov_w[g]    = bus[g].out_valid;
    assign oovf_w[g]  = bus[g].out_ovf;
    assign ocout_w[g] = bus[g].out_cout;
    assign sum_w[g]   = bus[g].out_sum;
    assign adda_w[g]  = bus[g].add_a;
    assign addb_w[g]  = bus[g].add_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          inst;
    logic [12:0] sum;
    logic        ovf;
    logic        cout;
  } exp_t;

  typedef struct {
    int          inst;
    int          n;
    logic [12:0] op [4];
    logic [12:0] sum;
    logic        ovf;
    logic        cout;
  } vec_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard pop: a result leaves the DUT at the edge after valid&&ready is seen here.
  always @(negedge clk) begin
    if (!reset) begin
      for (int g = 0; g < 3; g++) begin
        if (ov_w[g] && ordy[g]) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: inst %0d produced %h with nothing expected", g, sum_w[g]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_inst", g, e.inst);
            check("sb_sum", sum_w[g], e.sum);
            check("sb_ovf", oovf_w[g], e.ovf);
            check("sb_cout", ocout_w[g], ocout_w[g] === e.cout ? e.cout : e.cout);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int i, input logic [12:0] d);
    int guard = 0;
    vld[i] = 1'b1;
    dat[i] = d;
    @(negedge clk);
    check("add_b_passthrough", addb_w[i], d);
    while (!rdy_w[i] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (guard >= 40) check("drain_timeout", sb.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    e.inst = v.inst;
    e.sum  = v.sum;
    e.ovf  = v.ovf;
    e.cout = v.cout;
    sb.push_back(e);
    for (int k = 0; k < v.n; k++) begin
      send(v.inst, v.op[k]);
      // out_valid must rise exactly on the cycle after the last accept.
      check((k == v.n - 1) ? "latency_valid_high" : "latency_valid_low",
            ov_w[v.inst], (k == v.n - 1) ? 1 : 0);
    end
    wait_drain();
  endtask

  function automatic vec_t model(input int inst, input logic [12:0] op [4]);
    vec_t        v;
    int          acc, s, u;
    logic [12:0] w;
    v.inst = inst;
    v.n    = 4;
    v.op   = op;
    v.ovf  = 1'b0;
    v.cout = 1'b0;
    acc = int'($signed(op[0]));
    for (int k = 1; k < 4; k++) begin
      s = acc + int'($signed(op[k]));
      u = (acc & 32'h1FFF) + int'(op[k]);
      if (u > 32'h1FFF) v.cout = 1'b1;
      if (s > 4095 || s < -4096) begin
        v.ovf = 1'b1;
        if (inst != 1) begin
          acc = (s > 0) ? 4095 : -4096;
        end else begin
          w   = s[12:0];
          acc = int'($signed(w));
        end
      end else begin
        acc = s;
      end
    end
    v.sum = acc[12:0];
    return v;
  endfunction

  vec_t vt [9];

  initial begin
    #300000;
    $display("FAIL global_timeout");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    vec_t        v;
    logic [12:0] ops [4];

    vt[0] = '{0, 4, '{13'h0001, 13'h0002, 13'h0003, 13'h0004}, 13'h000A, 1'b0, 1'b0};
    vt[1] = '{0, 4, '{13'h0800, 13'h0800, 13'h0001, 13'h0001}, 13'h0FFF, 1'b1, 1'b0};
    vt[2] = '{0, 4, '{13'h1000, 13'h1FFF, 13'h0005, 13'h0000}, 13'h1005, 1'b1, 1'b1};
    vt[3] = '{1, 4, '{13'h1000, 13'h1FFF, 13'h0005, 13'h0000}, 13'h1004, 1'b1, 1'b1};
    vt[4] = '{1, 4, '{13'h0800, 13'h0800, 13'h0001, 13'h0001}, 13'h1002, 1'b1, 1'b0};
    vt[5] = '{1, 4, '{13'h0001, 13'h0002, 13'h0003, 13'h0004}, 13'h000A, 1'b0, 1'b0};
    vt[6] = '{2, 1, '{13'h1ABC, 13'h0000, 13'h0000, 13'h0000}, 13'h1ABC, 1'b0, 1'b0};
    vt[7] = '{2, 1, '{13'h0FFF, 13'h0000, 13'h0000, 13'h0000}, 13'h0FFF, 1'b0, 1'b0};
    vt[8] = '{2, 1, '{13'h0FFF, 13'h0000, 13'h0000, 13'h0000}, 13'h0FFF, 1'b0, 1'b0};

    // Reset with an operand offered on inst 0: reset must win.
    reset = 1'b1;
    vld   = '0;
    dat   = '0;
    ordy  = 3'b111;
    vld[0] = 1'b1;
    dat[0] = 13'h0055;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    vld   = '0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("reset_out_valid", ov_w[g], 0);
      check("reset_in_ready", rdy_w[g], 1);
      check("reset_acc", adda_w[g], 0);
      check("reset_ovf", oovf_w[g], 0);
      check("reset_cout", ocout_w[g], 0);
    end
    @(posedge clk);
    #1;

    for (int t = 0; t < 9; t++) run_vec(vt[t]);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) ops[k] = 13'($urandom_range(0, 8191));
      v = model(r % 2, ops);
      run_vec(v);
    end

    // Backpressure: result held, operands refused, then released.
    ordy[0] = 1'b0;
    begin
      exp_t e;
      e = '{0, 13'h00A0, 1'b0, 1'b0};
      sb.push_back(e);
    end
    send(0, 13'h0010);
    send(0, 13'h0020);
    send(0, 13'h0030);
    send(0, 13'h0040);
    vld[0] = 1'b1;
    dat[0] = 13'h0123;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", ov_w[0], 1);
      check("bp_out_sum", sum_w[0], 13'h00A0);
      check("bp_in_ready", rdy_w[0], 0);
    end
    @(posedge clk);
    #1;
    vld[0]  = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", ov_w[0], 0);
    check("bp_release_ready", rdy_w[0], 1);
    check("bp_acc_retained", adda_w[0], 13'h00A0);
    check("bp_sb_drained", sb.size(), 0);
    begin
      exp_t e;
      e = '{0, 13'h0008, 1'b0, 1'b0};
      sb.push_back(e);
    end
    send(0, 13'h0005);
    check("bp_load_acc", adda_w[0], 13'h0005);
    send(0, 13'h0001);
    send(0, 13'h0001);
    send(0, 13'h0001);
    wait_drain();

    // Bubbles do not advance the count; reset discards the partial sum.
    send(0, 13'h0007);
    repeat (3) @(posedge clk);
    #1;
    send(0, 13'h0007);
    repeat (2) @(posedge clk);
    #1;
    check("bubble_acc", adda_w[0], 13'h000E);
    check("bubble_valid", ov_w[0], 0);
    check("bubble_ready", rdy_w[0], 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_acc", adda_w[0], 0);
    check("midreset_ready", rdy_w[0], 1);
    check("midreset_ovf", oovf_w[0], 0);
    v = '{0, 4, '{13'h0007, 13'h0007, 13'h0007, 13'h0007}, 13'h001C, 1'b0, 1'b0};
    run_vec(v);

    // Reset while a result is waiting drops it without a handshake.
    ordy[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 13'h0001);
    check("outreset_pre_valid", ov_w[0], 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("outreset_valid", ov_w[0], 0);
    check("outreset_ready", rdy_w[0], 1);
    check("outreset_acc", adda_w[0], 0);
    ordy[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("sb_empty_at_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
